// File: rtl/ex_multicycle_ctrl_pkg.sv
// Purpose : shared encodings for the EX multi-cycle sequencer (FSM states,
//           stall vector bit positions, pass-counter codes, watchdog default).
// Latency : n/a (definitions only).
// Backpressure: n/a. Also provides the codebase macros ZeroWord, Stop/NoStop,
//           ResetEnable when they are not already defined elsewhere.

`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef ResetEnable
`define ResetEnable 1'b1
`endif

package ex_multicycle_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACC      = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } mc_state_e;

    // Positions in the 6-bit pipeline stall vector.
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    // Accumulate pass counter codes.
    localparam logic [1:0] CNT_IDLE  = 2'b00;
    localparam logic [1:0] CNT_PASS1 = 2'b01;
    localparam logic [1:0] CNT_PASS2 = 2'b10;

    // Default number of DIV_WAIT cycles before the watchdog aborts.
    localparam int unsigned DIV_TIMEOUT_DEF = 40;

endpackage

// File: rtl/ex_multicycle_ctrl_acc_unit.sv
// Purpose : 64-bit datapath for the two-pass MADD/MSUB accumulate.
// Latency : purely combinational, 0 cycles.
// Backpressure: none; the sequencer decides when the results are captured.
// Ports   : negate_i selects -product for MSUB; product_i is the multiplier
//           output; hilo_cur_i/partial_i are the second-pass addends;
//           pass1_o is the first-pass value, pass2_o the final sum.

module mc_acc_unit (
    input  logic        negate_i,
    input  logic [63:0] product_i,
    input  logic [63:0] hilo_cur_i,
    input  logic [63:0] partial_i,
    output logic [63:0] pass1_o,
    output logic [63:0] pass2_o
);

    // Two's complement negate; wraps naturally at 64 bits.
    assign pass1_o = negate_i ? (~product_i + 64'd1) : product_i;
    assign pass2_o = hilo_cur_i + partial_i;

endmodule

// File: rtl/ex_multicycle_ctrl.sv
// Purpose : sequences MADD/MADDU/MSUB/MSUBU (two passes) and DIV/DIVU (external
//           iterative divider) over the shared 64-bit HI/LO temporary path.
// Latency : accumulate = 2 cycles to DONE; divide = 1 cycle + divider time;
//           divide by zero = 1 cycle.
// Backpressure: raises stallreq_o while it needs EX held; holds ACC/DONE while
//           stall[3] is set by someone else.
// Ports   : clk/rst (sync, active-high); stall vector; multiply/divide requests
//           and operands from EX; divider handshake (start level, annul pulse,
//           ready pulse, result); hilo_tmp_o/cnt_o/hilo_valid_o back to EX/MEM.
// Option  : define DIV_WATCHDOG_EN to abort a divide after DIV_TIMEOUT cycles
//           in DIV_WAIT with an all-ones result.

module ex_multicycle_ctrl
    import ex_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        madd_req,
    input  logic        msub_req,
    input  logic [63:0] mul_result,
    input  logic [63:0] hilo_cur,
    input  logic        div_req,
    input  logic        div_signed_i,
    input  logic [31:0] div_op1_i,
    input  logic [31:0] div_op2_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic [1:0]  cnt_o,
    output logic [63:0] hilo_tmp_o,
    output logic        hilo_valid_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        busy_o
);

    mc_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] hilo_q, hilo_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;
    logic        annul_q, annul_d;
    logic        sgn_q, sgn_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [63:0] acc_pass1, acc_pass2;
    logic        wd_expired;

    // madd wins over msub, so only negate when msub is the sole request.
    mc_acc_unit u_acc (
        .negate_i   (msub_req & ~madd_req),
        .product_i  (mul_result),
        .hilo_cur_i (hilo_cur),
        .partial_i  (hilo_q),
        .pass1_o    (acc_pass1),
        .pass2_o    (acc_pass2)
    );

`ifdef DIV_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(DIV_TIMEOUT + 1);
    logic [WdW-1:0] wd_cnt_q;

    // Counts cycles spent in DIV_WAIT; restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst == `ResetEnable || state_q != ST_DIV_WAIT) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt_q == WdW'(DIV_TIMEOUT - 1));
`else
    localparam int unsigned UnusedTimeout = DIV_TIMEOUT;
    assign wd_expired = 1'b0;
`endif

    // Only the EX hold bit matters here; the rest of the vector is ignored.
    logic unused_stall;
    assign unused_stall = ^{stall[5:STALL_MEM], stall[STALL_EX-1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hilo_d     = hilo_q;
        valid_d    = valid_q;
        start_d    = start_q;
        annul_d    = 1'b0;
        sgn_d      = sgn_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        stallreq_o = `NoStop;

        case (state_q)
            ST_IDLE: begin
                if (div_req) begin
                    stallreq_o = `Stop;
                    if (div_op2_i == `ZeroWord) begin
                        // Divide by zero never reaches the divider.
                        hilo_d  = {`ZeroWord, `ZeroWord};
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        sgn_d   = div_signed_i;
                        op1_d   = div_op1_i;
                        op2_d   = div_op2_i;
                        start_d = 1'b1;
                        state_d = ST_DIV_WAIT;
                    end
                end else if (madd_req || msub_req) begin
                    stallreq_o = `Stop;
                    hilo_d     = acc_pass1;
                    cnt_d      = CNT_PASS1;
                    state_d    = ST_ACC;
                end
            end
            ST_ACC: begin
                // A foreign EX stall freezes the second pass.
                if (!stall[STALL_EX]) begin
                    hilo_d  = acc_pass2;
                    cnt_d   = CNT_PASS2;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DIV_WAIT: begin
                stallreq_o = `Stop;
                if (div_ready_i) begin
                    hilo_d  = div_result_i;
                    valid_d = 1'b1;
                    start_d = 1'b0;
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    annul_d = 1'b1;
                    hilo_d  = {64{1'b1}};
                    valid_d = 1'b1;
                    start_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall[STALL_EX]) begin
                    cnt_d   = CNT_IDLE;
                    hilo_d  = {`ZeroWord, `ZeroWord};
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle div_ready_i.
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_IDLE;
            hilo_d  = {`ZeroWord, `ZeroWord};
            valid_d = 1'b0;
            start_d = 1'b0;
            sgn_d   = 1'b0;
            op1_d   = `ZeroWord;
            op2_d   = `ZeroWord;
            annul_d = (state_q == ST_DIV_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == `ResetEnable) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_IDLE;
            hilo_q  <= {`ZeroWord, `ZeroWord};
            valid_q <= 1'b0;
            start_q <= 1'b0;
            annul_q <= 1'b0;
            sgn_q   <= 1'b0;
            op1_q   <= `ZeroWord;
            op2_q   <= `ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            valid_q <= valid_d;
            start_q <= start_d;
            annul_q <= annul_d;
            sgn_q   <= sgn_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign hilo_tmp_o   = hilo_q;
    assign hilo_valid_o = valid_q;
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = sgn_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// Purpose : directed self-checking bench for ex_multicycle_ctrl.
// Latency : n/a.
// Backpressure: n/a; stall vector driven directly.

module tb_ex_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        madd_req, msub_req, div_req, div_signed_i, div_ready_i, flush_i;
    logic [63:0] mul_result, hilo_cur, div_result_i;
    logic [31:0] div_op1_i, div_op2_i;
    logic        stallreq_o, hilo_valid_o, div_start_o, div_annul_o, div_signed_o, busy_o;
    logic [1:0]  cnt_o;
    logic [63:0] hilo_tmp_o;
    logic [31:0] div_op1_o, div_op2_o;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cycles;
    int start_drops;

    always #5 clk = ~clk;

    ex_multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .madd_req     (madd_req),
        .msub_req     (msub_req),
        .mul_result   (mul_result),
        .hilo_cur     (hilo_cur),
        .div_req      (div_req),
        .div_signed_i (div_signed_i),
        .div_op1_i    (div_op1_i),
        .div_op2_i    (div_op2_i),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .cnt_o        (cnt_o),
        .hilo_tmp_o   (hilo_tmp_o),
        .hilo_valid_o (hilo_valid_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All registered outputs back at their idle values.
    task automatic chk_idle(input string tag);
        chk({tag, "_cnt"},   cnt_o, 2'b00);
        chk({tag, "_hilo"},  hilo_tmp_o, 64'h0);
        chk({tag, "_valid"}, hilo_valid_o, 1'b0);
        chk({tag, "_start"}, div_start_o, 1'b0);
        chk({tag, "_busy"},  busy_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; madd_req = 0; msub_req = 0; div_req = 0;
        div_signed_i = 0; div_ready_i = 0; flush_i = 0;
        mul_result = '0; hilo_cur = '0; div_result_i = '0;
        div_op1_i = '0; div_op2_i = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_annul", div_annul_o, 1'b0);
        chk("reset_stallreq", stallreq_o, 1'b0);
        chk("reset_op1", div_op1_o, 32'h0);

        // MADD: 2 + 5 = 7, stall request for exactly the IDLE cycle.
        madd_req = 1; mul_result = 64'h2; hilo_cur = 64'h5;
        #1 chk("madd_stallreq_idle", stallreq_o, 1'b1);
        step();
        madd_req = 0;
        #1;
        chk("madd_cnt_pass1", cnt_o, 2'b01);
        chk("madd_hilo_pass1", hilo_tmp_o, 64'h2);
        chk("madd_stallreq_acc", stallreq_o, 1'b0);
        chk("madd_valid_acc", hilo_valid_o, 1'b0);
        step();
        chk("madd_cnt_pass2", cnt_o, 2'b10);
        chk("madd_hilo_final", hilo_tmp_o, 64'h7);
        chk("madd_valid", hilo_valid_o, 1'b1);
        chk("madd_stallreq_done", stallreq_o, 1'b0);
        step();
        chk_idle("madd_release");

        // MSUB: 1 + (-3) = -2.
        msub_req = 1; mul_result = 64'h3; hilo_cur = 64'h1;
        step();
        msub_req = 0;
        chk("msub_hilo_pass1", hilo_tmp_o, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        chk("msub_hilo_final", hilo_tmp_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("msub_valid", hilo_valid_o, 1'b1);
        step();
        chk_idle("msub_release");

        // DIV 100/7, ready on the 33rd DIV_WAIT cycle -> 34 stall cycles.
        stall_cycles = 0; start_drops = 0;
        div_req = 1; div_signed_i = 1; div_op1_i = 32'd100; div_op2_i = 32'd7;
        #1 if (stallreq_o) stall_cycles++;
        step();
        div_req = 0; div_signed_i = 0; div_op1_i = '0; div_op2_i = '0;
        chk("div_op1_latched", div_op1_o, 32'd100);
        chk("div_op2_latched", div_op2_o, 32'd7);
        chk("div_sign_latched", div_signed_o, 1'b1);
        for (int i = 1; i <= 33; i++) begin
            if (i == 33) begin
                div_ready_i = 1; div_result_i = {32'd2, 32'd14};
            end
            #1;
            if (stallreq_o) stall_cycles++;
            if (!div_start_o) start_drops++;
            step();
        end
        div_ready_i = 0; div_result_i = '0;
        chk("div_stall_cycles", stall_cycles, 34);
        chk("div_start_held", start_drops, 0);
        chk("div_result", hilo_tmp_o, {32'd2, 32'd14});
        chk("div_valid", hilo_valid_o, 1'b1);
        chk("div_start_dropped", div_start_o, 1'b0);
        chk("div_stallreq_done", stallreq_o, 1'b0);
        step();
        chk_idle("div_release");

        // Divide by zero: done in one cycle, divider never started.
        div_req = 1; div_op1_i = 32'd5; div_op2_i = 32'd0;
        #1 chk("div0_stallreq", stallreq_o, 1'b1);
        step();
        div_req = 0;
        chk("div0_start", div_start_o, 1'b0);
        chk("div0_hilo", hilo_tmp_o, 64'h0);
        chk("div0_valid", hilo_valid_o, 1'b1);
        chk("div0_busy", busy_o, 1'b1);
        step();
        chk_idle("div0_release");

        // Flush in DIV_WAIT cycle 10, racing a ready pulse.
        div_req = 1; div_op1_i = 32'd50; div_op2_i = 32'd3;
        step();
        div_req = 0;
        for (int i = 1; i < 10; i++) step();
        chk("flush_pre_annul", div_annul_o, 1'b0);
        flush_i = 1; div_ready_i = 1; div_result_i = 64'hABC;
        step();
        flush_i = 0; div_ready_i = 0; div_result_i = '0;
        chk_idle("flush");
        chk("flush_annul", div_annul_o, 1'b1);
        chk("flush_op1_clr", div_op1_o, 32'h0);
        step();
        chk("flush_annul_pulse", div_annul_o, 1'b0);

        // Foreign stall holds ACC and DONE.
        madd_req = 1; mul_result = 64'h4; hilo_cur = 64'hA;
        step();
        madd_req = 0; stall = 6'b001000;
        step();
        chk("acc_hold_cnt", cnt_o, 2'b01);
        chk("acc_hold_hilo", hilo_tmp_o, 64'h4);
        stall = 6'b0;
        step();
        chk("acc_resume_hilo", hilo_tmp_o, 64'hE);
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold_hilo", hilo_tmp_o, 64'hE);
            chk("done_hold_cnt", cnt_o, 2'b10);
            chk("done_hold_valid", hilo_valid_o, 1'b1);
        end
        stall = 6'b0;
        step();
        chk_idle("done_release");

        // Reset mid-ACC.
        madd_req = 1; mul_result = 64'h9; hilo_cur = 64'h1;
        step();
        madd_req = 0;
        chk("rst_acc_pre_busy", busy_o, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk_idle("rst_acc");

        // Reset mid-DIV_WAIT: no annul pulse.
        div_req = 1; div_op1_i = 32'd9; div_op2_i = 32'd2;
        step();
        div_req = 0;
        chk("rst_div_pre_start", div_start_o, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk_idle("rst_div");
        chk("rst_div_annul", div_annul_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
